// File: rtl/key_e_sequencer_if.sv
// rtl/key_e_sequencer_if.sv - run control, RNG and GCD-checker handshake bundle for key_e_sequencer
interface key_e_sequencer_if;
  logic        start;
  logic [31:0] phi;
  logic        rng_req;
  logic        rng_valid;
  logic [31:0] rng_data;
  logic        gcd_rst;
  logic        gcd_start;
  logic [31:0] gcd_phi;
  logic [31:0] gcd_e;
  logic        gcd_valid;
  logic        gcd_redo;
  logic        busy;
  logic        done;
  logic        fail;
  logic        timeout;
  logic [31:0] e_key;
  logic [7:0]  attempts;

  modport master (
    input  start, phi, rng_valid, rng_data, gcd_valid, gcd_redo,
    output rng_req, gcd_rst, gcd_start, gcd_phi, gcd_e,
           busy, done, fail, timeout, e_key, attempts
  );

  modport slave (
    output start, phi, rng_valid, rng_data, gcd_valid, gcd_redo,
    input  rng_req, gcd_rst, gcd_start, gcd_phi, gcd_e,
           busy, done, fail, timeout, e_key, attempts
  );
endinterface

// File: rtl/key_e_sequencer.sv
// rtl/key_e_sequencer.sv - draws candidate public exponents from an RNG until a GCD checker accepts one
module key_e_sequencer #(
  parameter int MAX_TRIES = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic             clk,
  input  logic             rst,
  key_e_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, CLEAR, REQ, WAIT_RNG, FILTER, LAUNCH, WAIT_GCD, DONE, FAIL
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [15:0] wdog;
  logic        accept;
  logic        wd_hit;
  logic        last_try;
  logic        reject;
  logic        wd_expire;

  assign accept    = (state == IDLE || state == DONE || state == FAIL) && bus.start;
  assign wd_hit    = (wdog == 16'(TIMEOUT - 1));
  assign last_try  = (bus.attempts == 8'(MAX_TRIES));
  assign reject    = !bus.gcd_e[0] || (bus.gcd_e < 32'd3) || (bus.gcd_e >= bus.gcd_phi);
  // A strobe landing on the expiry cycle wins over the watchdog.
  assign wd_expire = wd_hit &&
                     ((state == WAIT_RNG && !bus.rng_valid) ||
                      (state == WAIT_GCD && !bus.gcd_valid && !bus.gcd_redo));

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, FAIL: if (bus.start) nxt = CLEAR;
      CLEAR:            nxt = REQ;
      REQ:              nxt = WAIT_RNG;
      WAIT_RNG: begin
        if (bus.rng_valid) nxt = FILTER;
        else if (wd_hit)   nxt = FAIL;
      end
      FILTER: begin
        if (!reject)       nxt = LAUNCH;
        else if (last_try) nxt = FAIL;
        else               nxt = REQ;
      end
      LAUNCH:             nxt = WAIT_GCD;
      WAIT_GCD: begin
        if (bus.gcd_valid)     nxt = DONE;
        else if (bus.gcd_redo) nxt = last_try ? FAIL : CLEAR;
        else if (wd_hit)       nxt = FAIL;
      end
      default:            nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wdog          <= 16'd0;
      bus.rng_req   <= 1'b0;
      bus.gcd_rst   <= 1'b0;
      bus.gcd_start <= 1'b0;
      bus.gcd_phi   <= 32'd0;
      bus.gcd_e     <= 32'd0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.fail      <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.e_key     <= 32'd0;
      bus.attempts  <= 8'd0;
    end else begin
      state         <= nxt;
      // Pulses and status flags are decoded from the next state so they line up with it.
      bus.gcd_rst   <= (nxt == CLEAR);
      bus.rng_req   <= (nxt == REQ);
      bus.gcd_start <= (nxt == LAUNCH);
      bus.busy      <= !(nxt == IDLE || nxt == DONE || nxt == FAIL);
      bus.done      <= (nxt == DONE);
      bus.fail      <= (nxt == FAIL);
      wdog          <= (state == WAIT_RNG || state == WAIT_GCD) ? wdog + 16'd1 : 16'd0;

      if (accept) begin
        bus.gcd_phi  <= bus.phi;
        bus.attempts <= 8'd0;
        bus.timeout  <= 1'b0;
        bus.e_key    <= 32'd0;
      end
      if (state == WAIT_RNG && bus.rng_valid) begin
        bus.gcd_e    <= bus.rng_data;
        bus.attempts <= bus.attempts + 8'd1;
      end
      if (state == WAIT_GCD && bus.gcd_valid) bus.e_key <= bus.gcd_e;
      if (nxt == FAIL && state != FAIL)       bus.e_key <= 32'd0;
      if (wd_expire)                          bus.timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_key_e_sequencer.sv
// tb/tb_key_e_sequencer.sv - directed checks of key_e_sequencer with MAX_TRIES=3, TIMEOUT=100
module tb_key_e_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_req = 0, n_rst = 0, n_st = 0, cyc_n = 0;
  int   last_rst_cyc = 0, last_req_cyc = 0;
  int   b_req, b_rst, b_st;

  key_e_sequencer_if bus ();

  key_e_sequencer #(.MAX_TRIES(3), .TIMEOUT(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_n++;
    if (bus.rng_req) begin n_req++; last_req_cyc = cyc_n; end
    if (bus.gcd_rst) begin n_rst++; last_rst_cyc = cyc_n; end
    if (bus.gcd_start) n_st++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_req = n_req; b_rst = n_rst; b_st = n_st;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_start(input logic [31:0] p);
    @(negedge clk); bus.start = 1'b1; bus.phi = p;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic find_req();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.rng_req) found = 1'b1;
    end
    chk("rng_req_seen", 64'(found), 64'd1);
  endtask

  task automatic supply(input logic [31:0] d);
    find_req();
    @(negedge clk); bus.rng_valid = 1'b1; bus.rng_data = d;
    @(negedge clk); bus.rng_valid = 1'b0;
  endtask

  task automatic find_start(input logic [31:0] exp_e);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.gcd_start) found = 1'b1;
    end
    chk("gcd_start_seen", 64'(found), 64'd1);
    chk("gcd_e_at_start", 64'(bus.gcd_e), 64'(exp_e));
    chk("gcd_phi_at_start", 64'(bus.gcd_phi), 64'd3120);
  endtask

  task automatic answer(input logic v, input logic r);
    @(negedge clk); bus.gcd_valid = v; bus.gcd_redo = r;
    @(negedge clk); bus.gcd_valid = 1'b0; bus.gcd_redo = 1'b0;
  endtask

  function automatic logic [127:0] all_out();
    return {bus.rng_req, bus.gcd_rst, bus.gcd_start, bus.busy, bus.done, bus.fail,
            bus.timeout, bus.attempts, bus.e_key, bus.gcd_e, bus.gcd_phi};
  endfunction

  initial begin
    bus.start = 1'b0; bus.phi = '0; bus.rng_valid = 1'b0; bus.rng_data = '0;
    bus.gcd_valid = 1'b0; bus.gcd_redo = 1'b0;
    cyc(2);
    chk("reset_outputs_zero", 64'(all_out() != '0), 64'd0);
    rst = 1'b0;
    cyc(2);
    chk("idle_not_busy", 64'(bus.busy), 64'd0);

    // Single good candidate
    snap();
    run_start(32'd3120);
    chk("clear_gcd_rst", 64'(bus.gcd_rst), 64'd1);
    chk("clear_busy", 64'(bus.busy), 64'd1);
    supply(32'd17);
    find_start(32'd17);
    answer(1'b1, 1'b0);
    chk("t1_done", 64'(bus.done), 64'd1);
    chk("t1_e_key", 64'(bus.e_key), 64'd17);
    chk("t1_attempts", 64'(bus.attempts), 64'd1);
    chk("t1_busy", 64'(bus.busy), 64'd0);
    chk("t1_n_rst", 64'(n_rst - b_rst), 64'd1);
    chk("t1_n_req", 64'(n_req - b_req), 64'd1);
    chk("t1_n_start", 64'(n_st - b_st), 64'd1);
    cyc(3);
    chk("t1_done_held", 64'(bus.done), 64'd1);

    // Even candidate filtered, then good one
    snap();
    run_start(32'd3120);
    chk("t2_done_cleared", 64'(bus.done), 64'd0);
    supply(32'd10);
    supply(32'd17);
    chk("t2_no_start_for_10", 64'(n_st - b_st), 64'd0);
    find_start(32'd17);
    answer(1'b1, 1'b0);
    chk("t2_done", 64'(bus.done), 64'd1);
    chk("t2_e_key", 64'(bus.e_key), 64'd17);
    chk("t2_attempts", 64'(bus.attempts), 64'd2);
    chk("t2_n_req", 64'(n_req - b_req), 64'd2);

    // Checker redo restarts from CLEAR
    snap();
    run_start(32'd3120);
    supply(32'd65);
    find_start(32'd65);
    answer(1'b0, 1'b1);
    supply(32'd17);
    chk("t3_rst_before_req", 64'(last_rst_cyc < last_req_cyc), 64'd1);
    find_start(32'd17);
    answer(1'b1, 1'b0);
    chk("t3_n_rst", 64'(n_rst - b_rst), 64'd2);
    chk("t3_n_req", 64'(n_req - b_req), 64'd2);
    chk("t3_done", 64'(bus.done), 64'd1);
    chk("t3_e_key", 64'(bus.e_key), 64'd17);
    chk("t3_attempts", 64'(bus.attempts), 64'd2);

    // Exhaust MAX_TRIES with rejects
    snap();
    run_start(32'd3120);
    supply(32'd4);
    supply(32'd6);
    supply(32'd3120);
    cyc(1);
    chk("t4_fail", 64'(bus.fail), 64'd1);
    chk("t4_timeout", 64'(bus.timeout), 64'd0);
    chk("t4_attempts", 64'(bus.attempts), 64'd3);
    chk("t4_e_key", 64'(bus.e_key), 64'd0);
    cyc(5);
    chk("t4_n_req", 64'(n_req - b_req), 64'd3);
    chk("t4_n_start", 64'(n_st - b_st), 64'd0);
    chk("t4_fail_held", 64'(bus.fail), 64'd1);

    // Watchdog expiry in WAIT_RNG
    run_start(32'd3120);
    find_req();
    cyc(100);
    chk("t5_no_fail_at_99", 64'(bus.fail), 64'd0);
    chk("t5_busy_at_99", 64'(bus.busy), 64'd1);
    cyc(1);
    chk("t5_fail", 64'(bus.fail), 64'd1);
    chk("t5_timeout", 64'(bus.timeout), 64'd1);
    chk("t5_busy", 64'(bus.busy), 64'd0);

    // Strobe on the expiry cycle wins
    run_start(32'd3120);
    chk("t6_timeout_cleared", 64'(bus.timeout), 64'd0);
    find_req();
    cyc(100);
    bus.rng_valid = 1'b1; bus.rng_data = 32'd17;
    @(negedge clk); bus.rng_valid = 1'b0;
    chk("t6_no_fail", 64'(bus.fail), 64'd0);
    chk("t6_attempts", 64'(bus.attempts), 64'd1);
    find_start(32'd17);
    answer(1'b1, 1'b0);
    chk("t6_done", 64'(bus.done), 64'd1);
    chk("t6_timeout", 64'(bus.timeout), 64'd0);

    // Asynchronous reset in WAIT_GCD
    run_start(32'd3120);
    supply(32'd17);
    find_start(32'd17);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("t7_async_zero", 64'(all_out() != '0), 64'd0);
    @(negedge clk); rst = 1'b0; bus.gcd_valid = 1'b1;
    @(negedge clk); bus.gcd_valid = 1'b0;
    cyc(2);
    chk("t7_valid_ignored", 64'(all_out() != '0), 64'd0);

    // Restart; start while busy ignored; valid+redo together means valid
    snap();
    run_start(32'd3120);
    chk("t8_clear_gcd_rst", 64'(bus.gcd_rst), 64'd1);
    supply(32'd17);
    find_start(32'd17);
    @(negedge clk); bus.start = 1'b1; bus.phi = 32'd5;
    @(negedge clk); bus.start = 1'b0;
    answer(1'b1, 1'b1);
    chk("t8_done", 64'(bus.done), 64'd1);
    chk("t8_e_key", 64'(bus.e_key), 64'd17);
    chk("t8_attempts", 64'(bus.attempts), 64'd1);
    chk("t8_phi_kept", 64'(bus.gcd_phi), 64'd3120);
    chk("t8_n_rst", 64'(n_rst - b_rst), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
